// File: rtl/lock_ctrl_pkg.sv
// Shared types and constants for the combination-lock controller and its top-level display decode.
package lock_ctrl_pkg;

    typedef enum logic [2:0] {
        StEntry   = 3'd0,
        StOpen    = 3'd1,
        StClosed  = 3'd2,
        StProg    = 3'd3,
        StLockout = 3'd4
    } lock_state_e;

    localparam logic [3:0] BcdMax = 4'd9;

    // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}, for OPEN/CLOSED/Err/LOC text
    localparam logic [6:0] SegO     = 7'b1000000;
    localparam logic [6:0] SegP     = 7'b0001100;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegN     = 7'b0101011;
    localparam logic [6:0] SegC     = 7'b1000110;
    localparam logic [6:0] SegL     = 7'b1000111;
    localparam logic [6:0] SegS     = 7'b0010010;
    localparam logic [6:0] SegD     = 7'b0100001;
    localparam logic [6:0] SegR     = 7'b0101111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    function automatic logic bcd_valid(input logic [3:0] d);
        return d <= BcdMax;
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Digit/strobe inputs and Moore status outputs of the lock controller.
interface lock_ctrl_if #(
    parameter int unsigned TimerW = 4
);
    logic [3:0]        digit_in;
    logic              enter;
    logic              prog;
    logic              relock;
    logic [2:0]        state_o;
    logic [2:0]        digit_idx;
    logic [1:0]        fail_cnt;
    logic              unlocked;
    logic              locked_out;
    logic [TimerW-1:0] lock_timer;
    logic              bad_digit;

    modport master (
        output digit_in, enter, prog, relock,
        input  state_o, digit_idx, fail_cnt, unlocked, locked_out, lock_timer, bad_digit
    );

    modport slave (
        input  digit_in, enter, prog, relock,
        output state_o, digit_idx, fail_cnt, unlocked, locked_out, lock_timer, bad_digit
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; times the lockout period.
module lock_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: digit entry, code reprogramming, failure counting and timed lockout.
module lock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned            NDIGITS      = 6,
    parameter int unsigned            MAX_FAIL     = 3,
    parameter int unsigned            LOCKOUT_CYC  = 16,
    parameter logic [4*NDIGITS-1:0]   DEFAULT_CODE = 24'h693002
) (
    input logic        clk,
    input logic        reset,
    lock_ctrl_if.slave bus
);

    localparam int unsigned        CodeW     = 4 * NDIGITS;
    localparam int unsigned        TimerW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [2:0]         LastIdx   = 3'(NDIGITS - 1);
    localparam logic [1:0]         MaxFail   = 2'(MAX_FAIL);
    localparam logic [TimerW-1:0]  TimerLoad = TimerW'(LOCKOUT_CYC - 1);
    localparam logic [CodeW-1:0]   NibMask   = CodeW'(4'hF);

    lock_state_e       state_q, state_d;
    logic [CodeW-1:0]  code_q, code_d;
    logic [CodeW-1:0]  shadow_q, shadow_d;
    logic [2:0]        idx_q, idx_d;
    logic              mism_q, mism_d;
    logic [1:0]        fail_q, fail_d;
    logic              bad_q, bad_d;

    logic              digit_ok, mism_all, last_digit;
    logic [4:0]        nib_sh;
    logic [CodeW-1:0]  code_sh, shadow_wr;
    logic [2:0]        fail_inc;
    logic              tmr_load, tmr_en, tmr_zero;
    logic [TimerW-1:0] tmr_cnt;

    // Digit 0 is the most significant nibble, so the shift counts from the top.
    assign nib_sh     = {LastIdx - idx_q, 2'b00};
    assign code_sh    = code_q >> nib_sh;
    assign digit_ok   = bcd_valid(bus.digit_in);
    assign mism_all   = mism_q | (code_sh[3:0] != bus.digit_in);
    assign last_digit = (idx_q == LastIdx);
    assign fail_inc   = {1'b0, fail_q} + 3'd1;
    assign shadow_wr  = (shadow_q & ~(NibMask << nib_sh)) | (CodeW'(bus.digit_in) << nib_sh);
    assign tmr_en     = (state_q == StLockout);

    lock_timer #(
        .Width(TimerW)
    ) u_lock_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load),
        .load_val_i (TimerLoad),
        .en_i       (tmr_en),
        .count_o    (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        bad_d    = 1'b0;
        tmr_load = 1'b0;

        unique case (state_q)
            StEntry: begin
                if (bus.relock) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (bus.enter) begin
                    if (!digit_ok) begin
                        bad_d = 1'b1;
                    end else if (last_digit) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!mism_all) begin
                            state_d = StOpen;
                            fail_d  = '0;
                        end else if (fail_inc < {1'b0, MaxFail}) begin
                            state_d = StClosed;
                            fail_d  = fail_inc[1:0];
                        end else begin
                            state_d  = StLockout;
                            fail_d   = MaxFail;
                            tmr_load = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        mism_d = mism_all;
                    end
                end
            end
            StOpen: begin
                if (bus.relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                end else if (bus.prog) begin
                    state_d = StProg;
                    idx_d   = '0;
                end
            end
            StClosed: begin
                if (bus.relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                end
            end
            StProg: begin
                if (bus.relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                end else if (bus.enter) begin
                    if (!digit_ok) begin
                        bad_d = 1'b1;
                    end else begin
                        shadow_d = shadow_wr;
                        if (last_digit) begin
                            code_d  = shadow_wr;
                            idx_d   = '0;
                            state_d = StOpen;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            StLockout: begin
                if (tmr_zero) begin
                    state_d = StEntry;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = StEntry;
                idx_d   = '0;
                mism_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEntry;
            code_q   <= DEFAULT_CODE;
            shadow_q <= DEFAULT_CODE;
            idx_q    <= '0;
            mism_q   <= 1'b0;
            fail_q   <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            mism_q   <= mism_d;
            fail_q   <= fail_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.digit_idx  = idx_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.unlocked   = (state_q == StOpen) || (state_q == StProg);
    assign bus.locked_out = (state_q == StLockout);
    assign bus.lock_timer = tmr_cnt;
    assign bus.bad_digit  = bad_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: directed vector table, corner sequences, random vs model.
module tb_lock_ctrl;

    localparam int NDIG = 6;
    localparam int MAXF = 3;
    localparam int LCYC = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lock_ctrl_if #(.TimerW(4)) bus ();

    lock_ctrl #(
        .NDIGITS      (NDIG),
        .MAX_FAIL     (MAXF),
        .LOCKOUT_CYC  (LCYC),
        .DEFAULT_CODE (24'h693002)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: state number, digit queue, code as an array of ints
    int m_state, m_fail, m_timer;
    bit m_bad;
    int m_code[NDIG];
    int m_q[$];
    int m_default[NDIG] = '{6, 9, 3, 0, 0, 2};

    typedef struct {
        logic [3:0] d;
        logic       e, p, r, rst;
        logic [2:0] st, idx;
        logic [1:0] fail;
        logic       bad;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [14:0] mk(int st, int idx, int fail, int tmr, bit bad);
        logic [14:0] v;
        v = {3'(st), 3'(idx), 2'(fail), 1'(st == 1 || st == 3), 1'(st == 4), 4'(tmr), bad};
        return v;
    endfunction

    function automatic logic [14:0] dut_status();
        return {bus.state_o, bus.digit_idx, bus.fail_cnt, bus.unlocked, bus.locked_out,
                bus.lock_timer, bus.bad_digit};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got st/idx/fail/unl/lo/tmr/bad=%b required %b", name, act, exp);
    endtask

    task automatic model_step(input int d, input bit e, input bit p, input bit r, input bit rst);
        bit ok;
        m_bad = 1'b0;
        if (rst) begin
            m_state = 0; m_fail = 0; m_timer = 0; m_q.delete(); m_code = m_default;
        end else begin
            case (m_state)
                0: if (r) m_q.delete();
                   else if (e) begin
                       if (d > 9) m_bad = 1'b1;
                       else begin
                           m_q.push_back(d);
                           if (m_q.size() == NDIG) begin
                               ok = 1'b1;
                               for (int i = 0; i < NDIG; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
                               m_q.delete();
                               if (ok) begin
                                   m_state = 1; m_fail = 0;
                               end else if (m_fail + 1 < MAXF) begin
                                   m_state = 2; m_fail++;
                               end else begin
                                   m_state = 4; m_fail = MAXF; m_timer = LCYC - 1;
                               end
                           end
                       end
                   end
                1: if (r) m_state = 0;
                   else if (p) begin m_state = 3; m_q.delete(); end
                2: if (r) m_state = 0;
                3: if (r) begin m_state = 0; m_q.delete(); end
                   else if (e) begin
                       if (d > 9) m_bad = 1'b1;
                       else begin
                           m_q.push_back(d);
                           if (m_q.size() == NDIG) begin
                               for (int i = 0; i < NDIG; i++) m_code[i] = m_q[i];
                               m_q.delete();
                               m_state = 1;
                           end
                       end
                   end
                4: if (m_timer == 0) begin m_state = 0; m_fail = 0; end
                   else m_timer--;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: drive, step the edge, sample #1 later, compare against the model
    task automatic tick(input logic [3:0] d, input bit e, input bit p, input bit r, input bit rst);
        bus.digit_in = d; bus.enter = e; bus.prog = p; bus.relock = r; reset = rst;
        @(posedge clk);
        #1;
        model_step(int'(d), e, p, r, rst);
        check("model", dut_status(), mk(m_state, m_q.size(), m_fail, m_timer, m_bad));
    endtask

    task automatic enter_code(input logic [23:0] c);
        for (int i = 0; i < NDIG; i++) tick(c[23-4*i -: 4], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic void add(input logic [3:0] d, input bit e, p, r, rst,
                                input int st, idx, fail, input bit bad);
        vec_t v;
        v.d = d; v.e = e; v.p = p; v.r = r; v.rst = rst;
        v.st = 3'(st); v.idx = 3'(idx); v.fail = 2'(fail); v.bad = bad;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] rd;
        bus.digit_in = '0; bus.enter = 1'b0; bus.prog = 1'b0; bus.relock = 1'b0;

        //   d    e p r rst st idx fail bad
        add(4'h0, 0,0,0,1,  0, 0, 0, 0);
        add(4'h6, 1,0,0,0,  0, 1, 0, 0);
        add(4'h9, 1,0,0,0,  0, 2, 0, 0);
        add(4'h3, 1,0,0,0,  0, 3, 0, 0);
        add(4'h0, 1,0,0,0,  0, 4, 0, 0);
        add(4'h0, 1,0,0,0,  0, 5, 0, 0);
        add(4'h2, 1,0,0,0,  1, 0, 0, 0);
        add(4'h5, 1,0,0,0,  1, 0, 0, 0);
        add(4'h0, 0,0,1,0,  0, 0, 0, 0);
        add(4'h6, 1,0,0,0,  0, 1, 0, 0);
        add(4'h9, 1,0,0,0,  0, 2, 0, 0);
        add(4'h3, 1,0,0,0,  0, 3, 0, 0);
        add(4'hA, 1,0,0,0,  0, 3, 0, 1);
        add(4'h0, 1,0,0,0,  0, 4, 0, 0);
        add(4'h0, 1,0,0,0,  0, 5, 0, 0);
        add(4'h2, 1,0,0,0,  1, 0, 0, 0);
        add(4'h7, 1,1,0,0,  3, 0, 0, 0);
        add(4'h1, 1,0,0,0,  3, 1, 0, 0);
        add(4'h2, 1,0,0,0,  3, 2, 0, 0);
        add(4'hF, 1,0,0,0,  3, 2, 0, 1);
        add(4'h3, 1,0,0,0,  3, 3, 0, 0);
        add(4'h4, 1,0,0,0,  3, 4, 0, 0);
        add(4'h5, 1,0,0,0,  3, 5, 0, 0);
        add(4'h6, 1,0,0,0,  1, 0, 0, 0);
        add(4'h0, 1,1,1,0,  0, 0, 0, 0);
        add(4'h1, 1,0,0,0,  0, 1, 0, 0);
        add(4'h2, 1,0,0,0,  0, 2, 0, 0);
        add(4'h3, 1,0,0,0,  0, 3, 0, 0);
        add(4'h4, 1,0,0,0,  0, 4, 0, 0);
        add(4'h5, 1,0,0,0,  0, 5, 0, 0);
        add(4'h6, 1,0,0,0,  1, 0, 0, 0);
        add(4'h0, 0,0,1,0,  0, 0, 0, 0);
        add(4'h6, 1,0,0,0,  0, 1, 0, 0);
        add(4'h9, 1,0,0,0,  0, 2, 0, 0);
        add(4'h3, 1,0,0,0,  0, 3, 0, 0);
        add(4'h0, 1,0,0,0,  0, 4, 0, 0);
        add(4'h0, 1,0,0,0,  0, 5, 0, 0);
        add(4'h2, 1,0,0,0,  2, 0, 1, 0);
        add(4'h6, 1,1,0,0,  2, 0, 1, 0);
        add(4'h0, 0,0,1,0,  0, 0, 1, 0);
        add(4'h0, 0,0,0,1,  0, 0, 0, 0);
        add(4'h6, 1,0,0,0,  0, 1, 0, 0);
        add(4'h9, 1,0,0,0,  0, 2, 0, 0);
        add(4'h3, 1,0,0,0,  0, 3, 0, 0);
        add(4'h0, 1,0,0,0,  0, 4, 0, 0);
        add(4'h0, 1,0,0,0,  0, 5, 0, 0);
        add(4'h2, 1,0,0,0,  1, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].r, vecs[i].rst);
            check($sformatf("vec%0d", i), dut_status(),
                  mk(vecs[i].st, vecs[i].idx, vecs[i].fail, 0, vecs[i].bad));
        end

        // Three failures into lockout, strobes ignored during the countdown
        tick(4'h0, 0, 0, 0, 1);
        enter_code(24'h693005);
        check("p2_fail1", dut_status(), mk(2, 0, 1, 0, 0));
        tick(4'h0, 0, 0, 1, 0);
        enter_code(24'h693005);
        check("p2_fail2", dut_status(), mk(2, 0, 2, 0, 0));
        tick(4'h0, 0, 0, 1, 0);
        enter_code(24'h693005);
        check("p2_lockout", dut_status(), mk(4, 0, 3, 15, 0));
        for (int k = 1; k <= 15; k++) begin
            tick(4'(k), 1, k[0], 1'b0, 1'b0);
            check($sformatf("p2_count%0d", k), dut_status(), mk(4, 0, 3, 15 - k, 0));
        end
        tick(4'h6, 1, 0, 0, 0);
        check("p2_release", dut_status(), mk(0, 0, 0, 0, 0));

        // Abort PROG with relock+enter; old code still opens
        tick(4'h0, 0, 0, 0, 1);
        enter_code(24'h693002);
        tick(4'h0, 0, 1, 0, 0);
        tick(4'h1, 1, 0, 0, 0);
        tick(4'h2, 1, 0, 0, 0);
        check("p5_prog2", dut_status(), mk(3, 2, 0, 0, 0));
        tick(4'h3, 1, 0, 1, 0);
        check("p5_abort", dut_status(), mk(0, 0, 0, 0, 0));
        enter_code(24'h693002);
        check("p5_oldcode", dut_status(), mk(1, 0, 0, 0, 0));

        // Reprogram, lock out with the old code, reset mid-countdown, default code restored
        tick(4'h0, 0, 1, 0, 0);
        enter_code(24'h123456);
        check("p6_prog", dut_status(), mk(1, 0, 0, 0, 0));
        for (int a = 0; a < MAXF; a++) begin
            tick(4'h0, 0, 0, 1, 0);
            enter_code(24'h693002);
        end
        for (int k = 0; k < 8; k++) tick(4'h0, 0, 0, 0, 0);
        check("p6_timer7", dut_status(), mk(4, 0, 3, 7, 0));
        tick(4'h0, 0, 0, 0, 1);
        check("p6_reset", dut_status(), mk(0, 0, 0, 0, 0));
        enter_code(24'h693002);
        check("p6_default", dut_status(), mk(1, 0, 0, 0, 0));

        // Random traffic biased toward correct digits so every state is visited
        for (int n = 0; n < 3000; n++) begin
            if (m_state == 0 && $urandom_range(3) != 0 && m_q.size() < NDIG)
                rd = 4'(m_code[m_q.size()]);
            else
                rd = 4'($urandom_range(15));
            tick(rd, $urandom_range(1) == 1, $urandom_range(7) == 0,
                 $urandom_range(15) == 0, $urandom_range(299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
